sha_job_ctrl: RTL

Job controller at the input and output ends of the pipelined SHA-256 miner block. It accepts one mining job: midstate, header tail, target and an inclusive nonce range. It then drives the pipeline's en/nonce/M/H_prev inputs with one nonce per cycle and consumes the pipeline's en_next/H/nonce_out results. It reports the first nonce whose hash meets the target, and signals completion once every issued nonce has returned.

---
 rtl/sha_job_ctrl_pkg.sv | 30 +++
 rtl/sha_target_cmp.sv | 31 +++
 rtl/sha_job_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sha_job_ctrl_pkg.sv
// rtl/sha_job_ctrl_pkg.sv - shared SHA-256 sizes, message layout and job FSM state type
package sha_job_ctrl_pkg;

   localparam int WORD_S    = 32;
   localparam int H_SIZE    = 256;
   localparam int MSG_S     = 512;
   localparam int TAIL_S    = 96;
   localparam int NONCE_POS = 384;

   // Second-block padding for an 80-byte header: marker bit, zeros, bit length 640.
   localparam logic [NONCE_POS-1:0] SHA_PAD_640 = {1'b1, 319'b0, 64'd640};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } job_state_t;

   function automatic logic [MSG_S-1:0] build_msg(input logic [TAIL_S-1:0] tail,
                                                  input logic [WORD_S-1:0] nonce);
      logic [MSG_S-1:0] msg;
      msg                         = '0;
      msg[MSG_S-1 -: TAIL_S]      = tail;
      msg[NONCE_POS +: WORD_S]    = nonce;
      msg[NONCE_POS-1:0]          = SHA_PAD_640;
      return msg;
   endfunction

endpackage

// File: rtl/sha_target_cmp.sv
// rtl/sha_target_cmp.sv - registered unsigned value <= limit compare with valid and tag pass-through
module sha_target_cmp #(
   parameter int W     = 256,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [W-1:0]     in_value,
   input  logic [W-1:0]     in_limit,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic             out_le,
   output logic [TAG_W-1:0] out_tag
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_le    <= 1'b0;
         out_tag   <= '0;
      end else begin
         out_valid <= in_valid;
         out_le    <= (in_value <= in_limit);
         if (in_valid) begin
            out_tag <= in_tag;
         end
      end
   end

endmodule

// File: rtl/sha_job_ctrl.sv
// rtl/sha_job_ctrl.sv - mining job controller: issues nonces to the SHA pipeline and records the first hit
module sha_job_ctrl
   import sha_job_ctrl_pkg::*;
#(
   parameter int INFLIGHT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [H_SIZE-1:0]  job_midstate,
   input  logic [TAIL_S-1:0]  job_tail,
   input  logic [H_SIZE-1:0]  job_target,
   input  logic [WORD_S-1:0]  job_nonce_start,
   input  logic [WORD_S-1:0]  job_nonce_end,
   input  logic               abort,
   output logic               pipe_en,
   output logic [WORD_S-1:0]  pipe_nonce,
   output logic [MSG_S-1:0]   pipe_M,
   output logic [H_SIZE-1:0]  pipe_H_prev,
   input  logic               pipe_en_next,
   input  logic [H_SIZE-1:0]  pipe_H,
   input  logic [WORD_S-1:0]  pipe_nonce_out,
   output logic               busy,
   output logic               found,
   output logic [WORD_S-1:0]  found_nonce,
   output logic               done
);

   job_state_t state_q, state_d;

   logic [WORD_S:0]       nonce_q;
   logic [WORD_S:0]       end_q;
   logic [H_SIZE-1:0]     target_q;
   logic [H_SIZE-1:0]     midstate_q;
   logic [TAIL_S-1:0]     tail_q;
   logic                  loaded_q;
   logic                  pipe_en_q;
   logic [INFLIGHT_W-1:0] inflight_q;
   logic                  found_q;
   logic [WORD_S-1:0]     found_nonce_q;

   logic                  accept;
   logic                  range_empty;
   logic                  last_issue;
   logic                  ret_ok;
   logic                  cmp_valid;
   logic                  cmp_le;
   logic [WORD_S-1:0]     cmp_nonce;
   logic                  hit_live;
   logic                  hit_first;

   assign accept      = job_valid && (state_q == ST_IDLE);
   assign range_empty = job_nonce_start > job_nonce_end;
   // 33-bit counter so an end of 0xFFFFFFFF is reached without wrapping.
   assign last_issue  = nonce_q >= end_q;
   // Results with nothing outstanding (e.g. after a reset) are dropped here.
   assign ret_ok      = pipe_en_next && (inflight_q != '0);

   sha_target_cmp #(
      .W     (H_SIZE),
      .TAG_W (WORD_S)
   ) u_cmp (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (ret_ok),
      .in_value  (pipe_H),
      .in_limit  (target_q),
      .in_tag    (pipe_nonce_out),
      .out_valid (cmp_valid),
      .out_le    (cmp_le),
      .out_tag   (cmp_nonce)
   );

   assign hit_live  = cmp_valid && cmp_le && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
   assign hit_first = hit_live && !found_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = range_empty ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_issue || abort || hit_live) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((inflight_q == '0) && !pipe_en_next) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nonce_q    <= '0;
         end_q      <= '0;
         target_q   <= '0;
         midstate_q <= '0;
         tail_q     <= '0;
         loaded_q   <= 1'b0;
         pipe_en_q  <= 1'b0;
      end else begin
         pipe_en_q <= (state_d == ST_RUN);
         if (accept) begin
            nonce_q    <= {1'b0, job_nonce_start};
            end_q      <= {1'b0, job_nonce_end};
            target_q   <= job_target;
            midstate_q <= job_midstate;
            tail_q     <= job_tail;
            loaded_q   <= 1'b1;
         end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            nonce_q <= nonce_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_q <= '0;
      end else begin
         case ({pipe_en_q, ret_ok})
            2'b10:   inflight_q <= inflight_q + INFLIGHT_W'(1);
            2'b01:   inflight_q <= inflight_q - INFLIGHT_W'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         found_q       <= 1'b0;
         found_nonce_q <= '0;
      end else if (accept) begin
         found_q       <= 1'b0;
         found_nonce_q <= '0;
      end else if (hit_first) begin
         found_q       <= 1'b1;
         found_nonce_q <= cmp_nonce;
      end
   end

   // The hit is visible in the cycle it leaves the comparator; issue stops one edge later.
   assign found       = found_q || hit_first;
   assign found_nonce = hit_first ? cmp_nonce : found_nonce_q;

   assign job_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign pipe_en     = pipe_en_q;
   assign pipe_nonce  = nonce_q[WORD_S-1:0];
   assign pipe_H_prev = midstate_q;
   assign pipe_M      = loaded_q ? build_msg(tail_q, nonce_q[WORD_S-1:0]) : '0;

endmodule
